// File: rtl/pmp_csr_file.sv
// PMP CSR file: pmpcfg0-3 and pmpaddr0-15 behind a request/response CSR port.
// NA4 address matching is accepted only when PMP_NA4_EN is defined.
module pmp_csr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  priv_mode,
    output logic        csr_rsp_valid,
    input  logic        csr_rsp_ready,
    output logic [31:0] csr_rdata,
    output logic        csr_rsp_err,
    output logic [31:0] pmpcfg0_data,
    output logic [31:0] pmpcfg1_data,
    output logic [31:0] pmpcfg2_data,
    output logic [31:0] pmpcfg3_data,
    output logic [31:0] pmpaddr0_data,
    output logic [31:0] pmpaddr1_data,
    output logic [31:0] pmpaddr2_data,
    output logic [31:0] pmpaddr3_data,
    output logic [31:0] pmpaddr4_data,
    output logic [31:0] pmpaddr5_data,
    output logic [31:0] pmpaddr6_data,
    output logic [31:0] pmpaddr7_data,
    output logic [31:0] pmpaddr8_data,
    output logic [31:0] pmpaddr9_data,
    output logic [31:0] pmpaddr10_data,
    output logic [31:0] pmpaddr11_data,
    output logic [31:0] pmpaddr12_data,
    output logic [31:0] pmpaddr13_data,
    output logic [31:0] pmpaddr14_data,
    output logic [31:0] pmpaddr15_data
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ENTRIES = 16;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] PRIV_M   = 2'b00;
    localparam logic [1:0] A_TOR    = 2'b01;
    localparam logic [1:0] A_NA4    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [1:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      priv_q;

    // One byte per PMP entry; pmpcfgK holds entries 4K..4K+3, low entry in the low byte
    logic [ENTRIES-1:0][7:0]    cfg_q;
    logic [ENTRIES-1:0][XLEN-1:0] addr_reg_q;

    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            cfg_hit;
    logic            addr_hit;
    logic            illegal;
    logic            is_write;
    logic [1:0]      cfg_idx;
    logic [3:0]      entry_idx;
    logic [3:0]      next_idx;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] op_val;
    logic [XLEN-1:0] cfg_new;
    logic            addr_locked;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (csr_req_valid) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (csr_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
        end
    end

    // Request capture in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_READ;
            addr_q  <= 12'h000;
            wdata_q <= '0;
            priv_q  <= PRIV_M;
        end else if (state_q == IDLE && csr_req_valid) begin
            op_q    <= csr_op;
            addr_q  <= csr_addr;
            wdata_q <= csr_wdata;
            priv_q  <= priv_mode;
        end
    end

    // Address decode and access legality
    always_comb begin
        cfg_hit   = (addr_q[11:2] == 10'h0E8);
        addr_hit  = (addr_q[11:4] == 8'h3B);
        illegal   = !(cfg_hit || addr_hit) || (priv_q != PRIV_M);
        is_write  = (op_q != OP_READ);
        cfg_idx   = addr_q[1:0];
        entry_idx = addr_q[3:0];
        next_idx  = 4'(entry_idx + 4'd1);
        old_val   = '0;
        if (cfg_hit)
            old_val = cfg_q[{cfg_idx, 2'b00} +: 4];
        else if (addr_hit)
            old_val = addr_reg_q[entry_idx];
    end

    always_comb begin
        op_val = old_val;
        case (op_q)
            OP_WRITE: op_val = wdata_q;
            OP_SET:   op_val = old_val | wdata_q;
            OP_CLEAR: op_val = old_val & ~wdata_q;
            default:  op_val = old_val;
        endcase
    end

    // Per-byte WARL filtering of a pmpcfg update
    always_comb begin
        logic [7:0] ob;
        logic [7:0] nb;
        logic       keep;
        cfg_new = old_val;
        for (int b = 0; b < 4; b++) begin
            ob = old_val[8*b +: 8];
            nb = op_val[8*b +: 8];
            nb[6:5] = 2'b00;
            keep = ob[7] || (!nb[0] && nb[1]);
`ifndef PMP_NA4_EN
            keep = keep || (nb[4:3] == A_NA4);
`endif
            cfg_new[8*b +: 8] = keep ? ob : nb;
        end
    end

    // A locked entry, or a locked TOR entry above it, freezes pmpaddrN
    always_comb begin
        addr_locked = cfg_q[entry_idx][7];
        if (entry_idx != 4'd15 && cfg_q[next_idx][7] && cfg_q[next_idx][4:3] == A_TOR)
            addr_locked = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q      <= '0;
            addr_reg_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else if (state_q == EXEC) begin
            rdata_q <= illegal ? '0 : old_val;
            err_q   <= illegal;
            if (!illegal && is_write) begin
                if (cfg_hit)
                    cfg_q[{cfg_idx, 2'b00} +: 4] <= cfg_new;
                else if (addr_hit && !addr_locked)
                    addr_reg_q[entry_idx] <= op_val;
            end
        end
    end

    assign csr_req_ready  = req_ready_q;
    assign csr_rsp_valid  = rsp_valid_q;
    assign csr_rdata      = rdata_q;
    assign csr_rsp_err    = err_q;

    assign pmpcfg0_data   = cfg_q[3:0];
    assign pmpcfg1_data   = cfg_q[7:4];
    assign pmpcfg2_data   = cfg_q[11:8];
    assign pmpcfg3_data   = cfg_q[15:12];

    assign pmpaddr0_data  = addr_reg_q[0];
    assign pmpaddr1_data  = addr_reg_q[1];
    assign pmpaddr2_data  = addr_reg_q[2];
    assign pmpaddr3_data  = addr_reg_q[3];
    assign pmpaddr4_data  = addr_reg_q[4];
    assign pmpaddr5_data  = addr_reg_q[5];
    assign pmpaddr6_data  = addr_reg_q[6];
    assign pmpaddr7_data  = addr_reg_q[7];
    assign pmpaddr8_data  = addr_reg_q[8];
    assign pmpaddr9_data  = addr_reg_q[9];
    assign pmpaddr10_data = addr_reg_q[10];
    assign pmpaddr11_data = addr_reg_q[11];
    assign pmpaddr12_data = addr_reg_q[12];
    assign pmpaddr13_data = addr_reg_q[13];
    assign pmpaddr14_data = addr_reg_q[14];
    assign pmpaddr15_data = addr_reg_q[15];

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed bench for pmp_csr_file: access rules, lock/WARL behaviour, handshake and reset.
module tb_pmp_csr_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_req_valid = 1'b0;
    logic        csr_req_ready;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = 32'h0;
    logic [1:0]  priv_mode = 2'b00;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_rsp_err;
    logic [31:0] cfg [4];
    logic [31:0] pa [16];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pmp_csr_file dut (
        .clk(clk), .rst(rst),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .priv_mode(priv_mode),
        .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
        .csr_rdata(csr_rdata), .csr_rsp_err(csr_rsp_err),
        .pmpcfg0_data(cfg[0]), .pmpcfg1_data(cfg[1]), .pmpcfg2_data(cfg[2]), .pmpcfg3_data(cfg[3]),
        .pmpaddr0_data(pa[0]), .pmpaddr1_data(pa[1]), .pmpaddr2_data(pa[2]), .pmpaddr3_data(pa[3]),
        .pmpaddr4_data(pa[4]), .pmpaddr5_data(pa[5]), .pmpaddr6_data(pa[6]), .pmpaddr7_data(pa[7]),
        .pmpaddr8_data(pa[8]), .pmpaddr9_data(pa[9]), .pmpaddr10_data(pa[10]), .pmpaddr11_data(pa[11]),
        .pmpaddr12_data(pa[12]), .pmpaddr13_data(pa[13]), .pmpaddr14_data(pa[14]), .pmpaddr15_data(pa[15])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CSR transaction; hold keeps csr_rsp_ready low that many cycles in RESP
    task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [1:0] priv, input int hold,
                          output logic [31:0] rd, output logic er);
        int cnt;
        logic [31:0] rd0;
        logic        er0;
        csr_op = op; csr_addr = addr; csr_wdata = wd; priv_mode = priv;
        csr_req_valid = 1'b1;
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        cnt = 0;
        while (!csr_rsp_valid && cnt < 8) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", 32'(cnt), 32'd1);
        rd = csr_rdata;
        er = csr_rsp_err;
        rd0 = csr_rdata;
        er0 = csr_rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(csr_rsp_valid), 32'd1);
            chk("hold_rdata", csr_rdata, rd0);
            chk("hold_err", 32'(csr_rsp_err), 32'(er0));
            chk("hold_req_ready", 32'(csr_req_ready), 32'd0);
        end
        csr_rsp_ready = 1'b1;
        @(posedge clk); #1;
        csr_rsp_ready = 1'b0;
        chk("back_idle_ready", 32'(csr_req_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        chk("rst_rdata", csr_rdata, 32'h0);
        chk("rst_err", 32'(csr_rsp_err), 32'd0);
        chk("rst_req_ready", 32'(csr_req_ready), 32'd1);
        chk("rst_cfg0", cfg[0], 32'h0);
        chk("rst_cfg3", cfg[3], 32'h0);
        chk("rst_addr15", pa[15], 32'h0);

        // Basic write to pmpaddr0
        do_req(2'b01, 12'h3B0, 32'h0000_1000, 2'b00, 0, rd, er);
        chk("w_addr0_err", 32'(er), 32'd0);
        chk("w_addr0_rdata", rd, 32'h0);
        chk("w_addr0_reg", pa[0], 32'h0000_1000);
        do_req(2'b00, 12'h3B0, 32'hFFFF_FFFF, 2'b00, 0, rd, er);
        chk("r_addr0_rdata", rd, 32'h0000_1000);
        chk("r_addr0_noupd", pa[0], 32'h0000_1000);

        // Illegal accesses
        do_req(2'b00, 12'h3A0, 32'h0, 2'b10, 0, rd, er);
        chk("u_read_err", 32'(er), 32'd1);
        chk("u_read_rdata", rd, 32'h0);
        do_req(2'b01, 12'h3B0, 32'h0000_FFFF, 2'b01, 0, rd, er);
        chk("s_write_err", 32'(er), 32'd1);
        chk("s_write_rdata", rd, 32'h0);
        chk("s_write_noupd", pa[0], 32'h0000_1000);
        do_req(2'b01, 12'h3C0, 32'h1234_5678, 2'b00, 0, rd, er);
        chk("unmapped_err", 32'(er), 32'd1);
        chk("unmapped_rdata", rd, 32'h0);
        do_req(2'b01, 12'h3A4, 32'h0000_0007, 2'b00, 0, rd, er);
        chk("unmapped3a4_err", 32'(er), 32'd1);
        chk("unmapped3a4_cfg1", cfg[1], 32'h0);

        // Reserved R=0/W=1 byte and bits [6:5] masking
        do_req(2'b01, 12'h3A1, 32'h0000_0062, 2'b00, 0, rd, er);
        chk("cfg_rsvd_keep", cfg[1], 32'h0);
        do_req(2'b01, 12'h3A1, 32'h0000_0067, 2'b00, 0, rd, er);
        chk("cfg_mask65", cfg[1], 32'h0000_0007);
        do_req(2'b01, 12'h3A1, 32'h000F_6267, 2'b00, 0, rd, er);
        chk("cfg_multi_rdata", rd, 32'h0000_0007);
        chk("cfg_multi", cfg[1], 32'h000F_0007);
        do_req(2'b01, 12'h3A1, 32'h000F_1307, 2'b00, 0, rd, er);
`ifdef PMP_NA4_EN
        chk("cfg_na4", cfg[1], 32'h000F_1307);
`else
        chk("cfg_na4", cfg[1], 32'h000F_0007);
`endif

        // Set/clear on pmpaddr2 with a held response
        do_req(2'b01, 12'h3B2, 32'h0000_00F0, 2'b00, 0, rd, er);
        chk("addr2_w", pa[2], 32'h0000_00F0);
        do_req(2'b10, 12'h3B2, 32'h0F0F_0000, 2'b00, 5, rd, er);
        chk("addr2_set_rdata", rd, 32'h0000_00F0);
        chk("addr2_set", pa[2], 32'h0F0F_00F0);
        do_req(2'b11, 12'h3B2, 32'h0F00_0030, 2'b00, 5, rd, er);
        chk("addr2_clr_rdata", rd, 32'h0F0F_00F0);
        chk("addr2_clr_err", 32'(er), 32'd0);
        chk("addr2_clr", pa[2], 32'h000F_00C0);

        // Entry 1 locked TOR freezes pmpaddr0 and pmpaddr1
        do_req(2'b01, 12'h3A0, 32'h0000_8800, 2'b00, 0, rd, er);
        chk("cfg0_lock1", cfg[0], 32'h0000_8800);
        do_req(2'b01, 12'h3B0, 32'h0000_0055, 2'b00, 0, rd, er);
        chk("tor_lock_err", 32'(er), 32'd0);
        chk("tor_lock_rdata", rd, 32'h0000_1000);
        chk("tor_lock_addr0", pa[0], 32'h0000_1000);
        do_req(2'b01, 12'h3B1, 32'h0000_0077, 2'b00, 0, rd, er);
        chk("lock_addr1", pa[1], 32'h0);
        do_req(2'b11, 12'h3A0, 32'hFFFF_FFFF, 2'b00, 0, rd, er);
        chk("lock_clr_rdata", rd, 32'h0000_8800);
        chk("lock_clr_cfg0", cfg[0], 32'h0000_8800);

        // Reset with a request in flight: dropped, locks cleared
        csr_op = 2'b01; csr_addr = 12'h3B3; csr_wdata = 32'hDEAD_BEEF; priv_mode = 2'b00;
        csr_req_valid = 1'b1;
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rsp_valid", 32'(csr_rsp_valid), 32'd0);
        chk("midrst_addr3", pa[3], 32'h0);
        chk("midrst_cfg0", cfg[0], 32'h0);
        chk("midrst_addr2", pa[2], 32'h0);

        // Entry 0 locked TOR, entry 3 locked NAPOT
        do_req(2'b01, 12'h3A0, 32'h9800_0088, 2'b00, 0, rd, er);
        chk("lock_set_rdata", rd, 32'h0);
        chk("lock_set_cfg0", cfg[0], 32'h9800_0088);
        do_req(2'b01, 12'h3A0, 32'h0000_0000, 2'b00, 0, rd, er);
        chk("lock_hold_cfg0", cfg[0], 32'h9800_0088);
        do_req(2'b01, 12'h3B0, 32'h0000_1234, 2'b00, 0, rd, er);
        chk("self_lock_addr0", pa[0], 32'h0);
        do_req(2'b01, 12'h3BF, 32'h0000_ABCD, 2'b00, 0, rd, er);
        chk("addr15_ok", pa[15], 32'h0000_ABCD);
        do_req(2'b01, 12'h3B2, 32'h0000_0033, 2'b00, 0, rd, er);
        chk("napot_above_addr2", pa[2], 32'h0000_0033);
        do_req(2'b01, 12'h3B3, 32'h0000_0044, 2'b00, 0, rd, er);
        chk("self_lock_addr3", pa[3], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pmp_csr_file.md
PMP_CSR_FILE -- requirements
Module: pmp_csr_file

Interface
REQ-001 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-003 SHALL have port csr_req_valid, input, 1 bit, CSR request present.
REQ-004 SHALL have port csr_req_ready, output, 1 bit, request accepted when high with csr_req_valid.
REQ-005 SHALL have port csr_op, input, 2 bits, request operation: 00 read, 01 write, 10 set, 11 clear.
REQ-006 SHALL have port csr_addr, input, 12 bits, CSR number.
REQ-007 SHALL have port csr_wdata, input, 32 bits, write, set or clear operand.
REQ-008 SHALL have port priv_mode, input, 2 bits, requester privilege: 00 M, 01 S, 10 U.
REQ-009 SHALL have port csr_rsp_valid, output, 1 bit, response present.
REQ-010 SHALL have port csr_rsp_ready, input, 1 bit, response consumed.
REQ-011 SHALL have port csr_rdata, output, 32 bits, old CSR value.
REQ-012 SHALL have port csr_rsp_err, output, 1 bit, illegal access.
REQ-013 SHALL have ports pmpcfg0_data to pmpcfg3_data, outputs, 32 bits each, architectural pmpcfg registers for the PMP checker.
REQ-014 SHALL have ports pmpaddr0_data to pmpaddr15_data, outputs, 32 bits each, architectural pmpaddr registers for the PMP checker.

Function
REQ-015 SHALL implement FSM IDLE, EXEC, RESP; csr_req_ready=1 only in IDLE.
REQ-016 IDLE: on csr_req_valid, SHALL latch op, addr, wdata and priv_mode, then go to EXEC.
REQ-017 EXEC: SHALL perform the access, update registers at the end of this cycle, then go to RESP.
REQ-018 RESP: SHALL hold csr_rsp_valid=1 with stable rdata and err; on csr_rsp_ready it SHALL go to IDLE. Minimum request-to-response latency is 2 cycles.
REQ-019 Address map: 0x3A0-0x3A3 SHALL map to pmpcfg0-3; 0x3B0-0x3BF SHALL map to pmpaddr0-15.
REQ-020 An unmapped address or priv_mode!=00 SHALL set err=1 and rdata=0, with no state change.
REQ-021 rdata SHALL be the pre-update register value.
REQ-022 New value SHALL be wdata for write, old|wdata for set, and old&~wdata for clear; read SHALL make no update.
REQ-023 pmpcfg writes SHALL be evaluated per byte. A byte whose current L=1 SHALL keep its old value.
REQ-024 In each updated cfg byte, bits [6:5] SHALL be forced to 0.
REQ-025 A cfg byte with new R=0 and W=1 (reserved) SHALL keep its old value entirely.
REQ-026 pmpaddrN SHALL ignore a write if cfgN.L=1, or if N<15 and cfg(N+1).L=1 with cfg(N+1).A=01 (TOR).
REQ-027 A locked or WARL-suppressed update SHALL still return err=0 and a normal rdata.
REQ-028 Lock checks SHALL use register values at EXEC, so a cfg write that sets L affects the following request only.
REQ-029 pmp*_data outputs SHALL be direct register outputs, never combinational from the request.

Reset
REQ-030 On rst: all pmpcfg and pmpaddr SHALL be 0, FSM=IDLE, csr_rsp_valid=0, csr_rdata=0, csr_rsp_err=0. A request in flight at reset SHALL be dropped with no update and no response.
REQ-031 Reset SHALL be the only path that clears a set L bit.

Configuration
REQ-032 The macro PMP_NA4_EN SHALL control the NA4 mode (A=10). Defined: A=10 SHALL be stored as written. Undefined: a cfg byte with new A=10 SHALL keep its old value, as in REQ-025.

Verification
REQ-033 Reset, then M-mode write 0x3B0 wdata 0x0000_1000 -> rsp err=0, rdata=0; pmpaddr0_data=0x0000_1000.
REQ-034 M-mode write 0x3A0 wdata 0x0000_0088 (cfg0 L=1, A=TOR), then write 0x3A0 0x0 -> pmpcfg0_data stays 0x0000_0088; write 0x3B0 is ignored; write 0x3BF succeeds.
REQ-035 With cfg1=0x88 and cfg0=0, write 0x3B0 0x55 -> pmpaddr0 unchanged, err=0.
REQ-036 U-mode (priv 10) read 0x3A0, and M-mode access 0x3C0 -> err=1, rdata=0, no register change.
REQ-037 Write 0x3A0 0x0000_0062 -> byte0 reserved (R=0, W=1), byte stays 0; write 0x0000_0067 -> stored 0x07.
REQ-038 Hold csr_rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, csr_req_ready=0; set csr_op=10 then 11 on pmpaddr2 and check OR/AND-NOT results.
